// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low glyph table, bit positions and scan FSM states.
// The encoder and the scan decoder both pull their glyphs from here.
package seg7_pkg;

    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [6:0] GLYPH_0 = 7'b0000001;
    localparam logic [6:0] GLYPH_1 = 7'b1001111;
    localparam logic [6:0] GLYPH_2 = 7'b0010010;
    localparam logic [6:0] GLYPH_3 = 7'b0000110;
    localparam logic [6:0] GLYPH_4 = 7'b1001100;
    localparam logic [6:0] GLYPH_5 = 7'b0100100;
    localparam logic [6:0] GLYPH_6 = 7'b0100000;
    localparam logic [6:0] GLYPH_7 = 7'b0001111;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0000100;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b1100000;
    localparam logic [6:0] GLYPH_C = 7'b0110001;
    localparam logic [6:0] GLYPH_D = 7'b1000010;
    localparam logic [6:0] GLYPH_E = 7'b0110000;
    localparam logic [6:0] GLYPH_F = 7'b0111000;

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_HELD   = 1'b1
    } scan_state_e;

    // Segment pattern {a..g} for a hex value; used by both ends of the display link.
    function automatic logic [6:0] glyph_pattern(input logic [3:0] value);
        case (value)
            4'h0:    glyph_pattern = GLYPH_0;
            4'h1:    glyph_pattern = GLYPH_1;
            4'h2:    glyph_pattern = GLYPH_2;
            4'h3:    glyph_pattern = GLYPH_3;
            4'h4:    glyph_pattern = GLYPH_4;
            4'h5:    glyph_pattern = GLYPH_5;
            4'h6:    glyph_pattern = GLYPH_6;
            4'h7:    glyph_pattern = GLYPH_7;
            4'h8:    glyph_pattern = GLYPH_8;
            4'h9:    glyph_pattern = GLYPH_9;
            4'hA:    glyph_pattern = GLYPH_A;
            4'hB:    glyph_pattern = GLYPH_B;
            4'hC:    glyph_pattern = GLYPH_C;
            4'hD:    glyph_pattern = GLYPH_D;
            4'hE:    glyph_pattern = GLYPH_E;
            default: glyph_pattern = GLYPH_F;
        endcase
    endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational reverse lookup: active-low {a..g} pattern to hex value.
// hit_o is low when the pattern is not one of the 16 glyphs.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] value_o,
    output logic       hit_o
);

    logic [15:0] match;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_match
            assign match[gi] = (pattern_i == glyph_pattern(4'(gi)));
        end
    endgenerate

    // Glyphs are pairwise distinct, so at most one match bit is set.
    always_comb begin
        value_o = '0;
        hit_o   = |match;
        for (int k = 0; k < 16; k++) begin
            if (match[k]) begin
                value_o = 4'(k);
            end
        end
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Display read-back checker: samples a multiplexed active-low 7-seg bus, waits for a stable
// dwell, and captures the digit shown on the strobed position.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter  int N_DIGITS      = 4,
    parameter  int STABLE_CYCLES = 4,
    localparam int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              seg,
    input  logic [N_DIGITS-1:0]     an,
    input  logic                    clear,
    output logic [4*N_DIGITS-1:0]   digits,
    output logic [N_DIGITS-1:0]     dp_out,
    output logic [N_DIGITS-1:0]     digit_valid,
    output logic                    frame_valid,
    output logic                    code_err,
    output logic                    bus_err
);

    logic [N_DIGITS-1:0]   an_q, an_prev_q;
    logic [7:0]            seg_q, seg_prev_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    scan_state_e           state_q, state_d;
    logic [4*N_DIGITS-1:0] digits_q, digits_d;
    logic [N_DIGITS-1:0]   dp_q, dp_d;
    logic [N_DIGITS-1:0]   valid_q, valid_d;
    logic [N_DIGITS-1:0]   seen_q, seen_d;
    logic                  frame_q, frame_d;
    logic                  code_err_q, code_err_d;
    logic                  bus_err_q, bus_err_d;

    logic                  changed, capture, one_hot, blank;
    logic [3:0]            glyph_value;
    logic                  glyph_hit;

    seg7_glyph_decode u_decode (
        .pattern_i (seg_q[7:1]),
        .value_o   (glyph_value),
        .hit_o     (glyph_hit)
    );

    always_comb begin
        changed = {an_q, seg_q} != {an_prev_q, seg_prev_q};
        one_hot = $onehot(~an_q);
        blank   = &an_q;

        if (changed)
            cnt_d = '0;
        else if (cnt_q == CNT_W'(STABLE_CYCLES))
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + CNT_W'(1);

        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            ST_SETTLE: begin
                if (!changed && cnt_q == CNT_W'(STABLE_CYCLES - 2)) begin
                    capture = 1'b1;
                    state_d = ST_HELD;
                end
            end
            ST_HELD: begin
                if (changed) state_d = ST_SETTLE;
            end
            default: state_d = ST_SETTLE;
        endcase
    end

    // Capture datapath; clear wins over a same-edge capture, which is then consumed.
    always_comb begin
        digits_d   = digits_q;
        dp_d       = dp_q;
        valid_d    = valid_q;
        seen_d     = seen_q;
        frame_d    = 1'b0;
        code_err_d = code_err_q;
        bus_err_d  = bus_err_q;

        if (clear) begin
            seen_d     = '0;
            valid_d    = '0;
            code_err_d = 1'b0;
            bus_err_d  = 1'b0;
        end else if (capture) begin
            if (one_hot) begin
                for (int i = 0; i < N_DIGITS; i++) begin
                    if (!an_q[i]) begin
                        if (glyph_hit) digits_d[4*i +: 4] = glyph_value;
                        dp_d[i]    = ~seg_q[SEG_DP];
                        valid_d[i] = glyph_hit;
                        seen_d[i]  = 1'b1;
                    end
                end
                if (!glyph_hit) code_err_d = 1'b1;
                if (&seen_d) begin
                    frame_d = 1'b1;
                    seen_d  = '0;
                end
            end else if (!blank) begin
                bus_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q       <= '1;
            an_prev_q  <= '1;
            seg_q      <= SEG_BLANK;
            seg_prev_q <= SEG_BLANK;
            cnt_q      <= '0;
            state_q    <= ST_SETTLE;
            digits_q   <= '0;
            dp_q       <= '0;
            valid_q    <= '0;
            seen_q     <= '0;
            frame_q    <= 1'b0;
            code_err_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            an_q       <= an;
            an_prev_q  <= an_q;
            seg_q      <= seg;
            seg_prev_q <= seg_q;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            digits_q   <= digits_d;
            dp_q       <= dp_d;
            valid_q    <= valid_d;
            seen_q     <= seen_d;
            frame_q    <= frame_d;
            code_err_q <= code_err_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign digits      = digits_q;
    assign dp_out      = dp_q;
    assign digit_valid = valid_q;
    assign frame_valid = frame_q;
    assign code_err    = code_err_q;
    assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: vector table through a scoreboard queue,
// plus hand-written latency, clear-collision and async-reset sequences.
module tb_seg7_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [15:0] digits;
    logic [3:0]  dp_out;
    logic [3:0]  digit_valid;
    logic        frame_valid;
    logic        code_err;
    logic        bus_err;

    int errors    = 0;
    int checks    = 0;
    int frame_cnt = 0;

    typedef struct {
        logic [3:0]  an;
        logic [7:0]  seg;
        int          hold;
        logic [15:0] digits;
        logic [3:0]  dp;
        logic [3:0]  valid;
        logic        code;
        logic        bus;
        int          frames;
    } vec_t;

    vec_t vecs[10];
    vec_t sb_q[$];

    seg7_scan_decoder #(.N_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg         (seg),
        .an          (an),
        .clear       (clear),
        .digits      (digits),
        .dp_out      (dp_out),
        .digit_valid (digit_valid),
        .frame_valid (frame_valid),
        .code_err    (code_err),
        .bus_err     (bus_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && frame_valid) frame_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [15:0] d, input logic [3:0] dp,
                             input logic [3:0] v, input logic c, input logic b);
        check({tag, ".digits"},   32'(digits),      32'(d));
        check({tag, ".dp_out"},   32'(dp_out),      32'(dp));
        check({tag, ".valid"},    32'(digit_valid), 32'(v));
        check({tag, ".code_err"}, 32'(code_err),    32'(c));
        check({tag, ".bus_err"},  32'(bus_err),     32'(b));
    endtask

    task automatic drive(input logic [3:0] a, input logic [7:0] s);
        @(negedge clk);
        an  = a;
        seg = s;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1;
    endtask

    initial begin
        automatic int   base;
        automatic vec_t exp_v;

        //           an       seg     hold digits   dp       valid    code  bus   frames
        vecs[0] = '{4'b1110, 8'h0D, 6, 16'h0003, 4'b0000, 4'b0001, 1'b0, 1'b0, 0};
        vecs[1] = '{4'b1101, 8'h11, 6, 16'h00A3, 4'b0000, 4'b0011, 1'b0, 1'b0, 0};
        vecs[2] = '{4'b1011, 8'hC1, 6, 16'h0BA3, 4'b0000, 4'b0111, 1'b0, 1'b0, 0};
        vecs[3] = '{4'b0111, 8'h71, 6, 16'hFBA3, 4'b0000, 4'b1111, 1'b0, 1'b0, 1};
        vecs[4] = '{4'b1110, 8'h00, 6, 16'hFBA8, 4'b0001, 4'b1111, 1'b0, 1'b0, 0};
        vecs[5] = '{4'b1101, 8'h00, 3, 16'hFBA8, 4'b0001, 4'b1111, 1'b0, 1'b0, 0};
        vecs[6] = '{4'b1111, 8'hFF, 6, 16'hFBA8, 4'b0001, 4'b1111, 1'b0, 1'b0, 0};
        vecs[7] = '{4'b1011, 8'hFE, 6, 16'hFBA8, 4'b0101, 4'b1011, 1'b1, 1'b0, 0};
        vecs[8] = '{4'b1100, 8'h9F, 6, 16'hFBA8, 4'b0101, 4'b1011, 1'b1, 1'b1, 0};
        vecs[9] = '{4'b1111, 8'hFF, 6, 16'hFBA8, 4'b0101, 4'b1011, 1'b1, 1'b1, 0};

        rst_n = 1'b0;
        clear = 1'b0;
        an    = 4'hF;
        seg   = 8'hFF;
        #2;
        check_all("reset", 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0);
        check("reset.frame", 32'(frame_valid), 32'd0);
        run(3);
        @(negedge clk);
        rst_n = 1'b1;

        // First capture lands exactly on edge 4 of the dwell
        drive(4'b1110, 8'h9F);
        run(4);
        check_all("lat.edge3", 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0);
        run(1);
        check_all("lat.edge4", 16'h0001, 4'h0, 4'h1, 1'b0, 1'b0);
        check("lat.frames", 32'(frame_cnt), 32'd0);

        pulse_clear();
        check_all("clear0", 16'h0001, 4'h0, 4'h0, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            base = frame_cnt;
            drive(vecs[i].an, vecs[i].seg);
            sb_q.push_back(vecs[i]);
            run(vecs[i].hold);
            exp_v = sb_q.pop_front();
            check_all($sformatf("vec%0d", i), exp_v.digits, exp_v.dp, exp_v.valid,
                      exp_v.code, exp_v.bus);
            check($sformatf("vec%0d.frames", i), 32'(frame_cnt - base), 32'(exp_v.frames));
            $display("vec%0d an=%b seg=%h -> digits=%h dp=%b valid=%b code=%b bus=%b",
                     i, vecs[i].an, vecs[i].seg, digits, dp_out, digit_valid, code_err, bus_err);
        end

        // Clear drops sticky flags and validity but keeps captured digits
        pulse_clear();
        check_all("clear1", 16'hFBA8, 4'b0101, 4'h0, 1'b0, 1'b0);

        base = frame_cnt;
        drive(4'b1110, 8'h49); run(6);
        drive(4'b1101, 8'h41); run(6);
        drive(4'b1011, 8'h1F); run(6);
        check_all("three", 16'hF765, 4'h0, 4'b0111, 1'b0, 1'b0);

        // Clear collides with the fourth capture: no frame, no update
        drive(4'b0111, 8'h09);
        run(4);
        @(negedge clk);
        clear = 1'b1;
        run(1);
        check_all("collide", 16'hF765, 4'h0, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        clear = 1'b0;
        run(4);
        check_all("collide.hold", 16'hF765, 4'h0, 4'h0, 1'b0, 1'b0);
        check("collide.frames", 32'(frame_cnt - base), 32'd0);

        // Async reset mid-dwell, then a full dwell is needed again
        drive(4'b1110, 8'h25);
        run(2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_all("areset", 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0);
        check("areset.frame", 32'(frame_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(4);
        check_all("post.edge3", 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0);
        run(1);
        check_all("post.edge4", 16'h0002, 4'h0, 4'h1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
